frog_ctrl: RTL
==============

Name: frog_ctrl

Overview:
- Downstream consumer of the car-lane generator's 16x16 grid (row 0 = bottom, bit 15 = leftmost column).
- Holds the frog position and moves it on debounced key presses.
- Detects collisions against the car bitmap and drives the sticky `hit` that freezes the lanes upstream.
- Counts successful crossings and produces the composite display grid (cars OR frog) for the LED driver.

Parameters:
- START_COL, 7, column bit index where the frog spawns (0..15).
- BLINK_DIV, 25_000_000, clk cycles per blink half-period in HIT state (1..2^26-1).
- SCORE_MAX, 99, saturation value of score.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_up  in  1  synchronized, debounced level; move toward row 15
- key_down  in  1  level; move toward row 0
- key_left  in  1  level; column index +1 (toward bit 15)
- key_right  in  1  level; column index -1
- restart  in  1  level; leaves HIT state
- grid_in  in  16x16  car bitmap, grid_in[row][col]
- grid_out  out  16x16  grid_in OR frog bit (frog bit gated by blink in HIT)
- frog_row  out  4  current row
- frog_col  out  4  current column bit index
- hit  out  1  registered, sticky collision flag
- score  out  7  crossings completed, saturating

Behaviour:
- Reset values:
  - frog_row=0, frog_col=START_COL, hit=0, score=0, state=PLAY, blink counter=0, blink phase=1.
  - Edge-detect history registers load the current key levels, so a key held through reset does not generate a press.
- Edge detection:
  - Each key and restart produces a press pulse when it is 1 now and was 0 last cycle.
  - A held key yields exactly one move.
- Move priority: if several presses arrive in one cycle, only the highest-priority one acts: up > down > left > right. The others are discarded, not queued.
- State PLAY:
  - The press updates frog_row/frog_col on the next edge.
  - Moves clamp at the edges: row 0 down, col 15 left and col 0 right leave the position unchanged.
  - Up from row 14 to row 15 is a crossing: the next cycle shows row 15. One cycle later the frog returns to row 0, START_COL, and score increments, saturating at SCORE_MAX.
  - Collision check: each cycle, if grid_in[frog_row][frog_col]==1 using the registered position, then hit<=1 and state<=HIT on the next edge. Latency is 1 cycle.
  - A collision takes precedence over a move press in the same cycle: the position holds.
  - Collision is checked while the frog is on row 15 too; the upstream block keeps rows 0, 1 and 15 empty, but this is not relied upon.
- State HIT:
  - hit stays 1 regardless of grid_in and keys.
  - Position and score hold; move presses are ignored.
  - The blink counter runs; when it reaches BLINK_DIV-1 it wraps to 0 and the phase toggles.
  - A restart press clears hit on the next edge, resets position to 0/START_COL, clears score and sets phase=1, returning to PLAY.
  - A restart press in PLAY is ignored.
- Output grid and position:
  - grid_out is combinational from the registers and grid_in.
  - In PLAY the frog bit is always set.
  - In HIT the frog bit is set only when phase=1.
  - frog_row/frog_col are register outputs.
- Reset asserted mid-operation (including in HIT) overrides everything in that cycle.

Decomposition:
- Package frogger_pkg holds:
  - typedef grid_t (logic [15:0][15:0]);
  - enum state_t {PLAY, HIT};
  - constants NROWS=16, NCOLS=16, START_ROW=0, GOAL_ROW=15.
- One sub-module, edge_pulse (clk, reset, level -> pulse), instantiated five times. Its reset loads the history register from level.

Test Plan:
- Reset with grid_in=0 -> frog_row=0, frog_col=7, hit=0, score=0; grid_out has only bit [0][7] set.
- Pulse key_up for 1 cycle, then hold key_left for 10 cycles -> row=1 after the first edge; then col=8, changing exactly once.
- From col 14 press left 3 times -> col=15, stays at 15. From row 0 press down -> row stays 0.
- Drive key_up and key_right high in the same cycle -> row+1, col unchanged.
- Frog at row 3, col 7; set grid_in[3][7]=1 for one cycle then 0 -> hit=1 the next cycle and stays 1. Press key_up -> position holds. With BLINK_DIV=4 the frog bit toggles every 4 cycles. Pulse restart -> hit=0, position 0/7, score=0.
- Make 15 up presses with grid_in=0 -> row reaches 15, next cycle row=0 and score=1. Preload 99 crossings -> score stays at 99.

Source files
------------

// File: rtl/frog_ctrl_pkg.sv
// Shared types and constants for the frog controller: grid layout, FSM states,
// and bit positions of the key/restart press vector.
package frogger_pkg;
    localparam int NROWS     = 16;
    localparam int NCOLS     = 16;
    localparam int START_ROW = 0;
    localparam int GOAL_ROW  = 15;

    // Bit positions in the press vector; lower index means higher move priority.
    localparam int K_UP = 0;
    localparam int K_DN = 1;
    localparam int K_LT = 2;
    localparam int K_RT = 3;
    localparam int K_RS = 4;
    localparam int NKEYS = 5;

    typedef logic [NROWS-1:0][NCOLS-1:0] grid_t;

    typedef enum logic {
        PLAY = 1'b0,
        HIT  = 1'b1
    } state_t;
endpackage

// File: rtl/frog_ctrl_if.sv
// Key inputs, car bitmap and display/status outputs of the frog controller.
interface frog_ctrl_if;
    import frogger_pkg::*;

    logic        key_up;
    logic        key_down;
    logic        key_left;
    logic        key_right;
    logic        restart;
    grid_t       grid_in;
    grid_t       grid_out;
    logic [3:0]  frog_row;
    logic [3:0]  frog_col;
    logic        hit;
    logic [6:0]  score;

    modport master (
        output key_up, key_down, key_left, key_right, restart, grid_in,
        input  grid_out, frog_row, frog_col, hit, score
    );

    modport slave (
        input  key_up, key_down, key_left, key_right, restart, grid_in,
        output grid_out, frog_row, frog_col, hit, score
    );
endinterface

// File: rtl/frog_ctrl_edge_pulse.sv
// Rising-edge detector; reset loads the history from the live level so a key
// held through reset never produces a press.
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic pulse_o
);
    logic prev_q;

    always_ff @(posedge clk) begin
        prev_q <= level_i;
    end

    assign pulse_o = level_i & ~prev_q & ~reset;
endmodule

// File: rtl/frog_ctrl.sv
// Frog position/collision/score controller; overlays the frog on the car grid
// and blinks it while frozen in HIT.
module frog_ctrl
    import frogger_pkg::*;
#(
    parameter int START_COL = 7,
    parameter int BLINK_DIV = 25_000_000,
    parameter int SCORE_MAX = 99
) (
    input  logic        clk,
    input  logic        reset,
    frog_ctrl_if.slave  fif
);
    localparam int CNT_W = 26;
    localparam logic [3:0]       START_C = 4'(START_COL);
    localparam logic [3:0]       START_R = 4'(START_ROW);
    localparam logic [3:0]       GOAL_R  = 4'(GOAL_ROW);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BLINK_DIV - 1);
    localparam logic [6:0]       SC_MAX  = 7'(SCORE_MAX);

    logic [NKEYS-1:0] key_lvl, key_prs;

    state_t           state_q, state_d;
    logic [3:0]       row_q, row_d, col_q, col_d;
    logic             hit_q, hit_d;
    logic [6:0]       score_q, score_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    grid_t            grid_o;

    assign key_lvl = {fif.restart, fif.key_right, fif.key_left, fif.key_down, fif.key_up};

    edge_pulse u_ep [NKEYS-1:0] (
        .clk     (clk),
        .reset   (reset),
        .level_i (key_lvl),
        .pulse_o (key_prs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PLAY;
            row_q   <= START_R;
            col_q   <= START_C;
            hit_q   <= 1'b0;
            score_q <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            hit_q   <= hit_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        hit_d   = hit_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        case (state_q)
            PLAY: begin
                cnt_d   = '0;
                phase_d = 1'b1;
                // Collision beats everything, including the goal-row return.
                if (fif.grid_in[row_q][col_q]) begin
                    state_d = HIT;
                    hit_d   = 1'b1;
                end else if (row_q == GOAL_R) begin
                    row_d = START_R;
                    col_d = START_C;
                    if (score_q < SC_MAX) score_d = score_q + 7'd1;
                end else if (key_prs[K_UP]) begin
                    row_d = row_q + 4'd1;
                end else if (key_prs[K_DN]) begin
                    if (row_q != 4'd0) row_d = row_q - 4'd1;
                end else if (key_prs[K_LT]) begin
                    if (col_q != 4'd15) col_d = col_q + 4'd1;
                end else if (key_prs[K_RT]) begin
                    if (col_q != 4'd0) col_d = col_q - 4'd1;
                end
            end
            HIT: begin
                if (key_prs[K_RS]) begin
                    state_d = PLAY;
                    hit_d   = 1'b0;
                    row_d   = START_R;
                    col_d   = START_C;
                    score_d = '0;
                    cnt_d   = '0;
                    phase_d = 1'b1;
                end else if (cnt_q == CNT_TOP) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_comb begin
        grid_o = fif.grid_in;
        if (state_q == PLAY || phase_q) grid_o[row_q][col_q] = 1'b1;
    end

    assign fif.grid_out = grid_o;
    assign fif.frog_row = row_q;
    assign fif.frog_col = col_q;
    assign fif.hit      = hit_q;
    assign fif.score    = score_q;
endmodule
